// File: rtl/cpmath_mem_pkg.sv
// rtl/cpmath_mem_pkg.sv - shared types and constants for the memory arbiter
package cpmath_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Grant IDs double as bit positions in the one-hot grant vector
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam int DEPTH_DEFAULT = 200;

endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-way round-robin between fetch and data ports
module mem_rr_arbiter
  import cpmath_mem_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the port that did not win last time is granted
  always_comb begin
    grant = 2'b00;
    if (if_req && d_req) begin
      grant = (last_grant == GNT_IF) ? 2'b10 : 2'b01;
    end else if (d_req) begin
      grant = 2'b10;
    end else if (if_req) begin
      grant = 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - sequences strobed word memory accesses for fetch and data ports
module mem_arbiter
  import cpmath_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ifReq,
  input  logic [AW-1:0] ifAdress,
  output logic          ifAck,
  output logic [DW-1:0] ifData,
  input  logic          dReq,
  input  logic          dWrite,
  input  logic [AW-1:0] dAdress,
  input  logic [DW-1:0] dWData,
  output logic          dAck,
  output logic [DW-1:0] dRData,
  output logic          dErr,
  output logic          ifErr,
  output logic [AW-1:0] memAdress,
  output logic [DW-1:0] memData,
  input  logic [DW-1:0] memOut,
  output logic          memRead,
  output logic          memWrite,
  output logic          busy
);

  localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH);

  state_t        state;
  state_t        next_state;
  logic          last_grant;
  logic          win;
  logic          lat_write;
  logic [1:0]    grant;
  logic          any_grant;
  logic [AW-1:0] sel_addr;
  logic          sel_oor;

  mem_rr_arbiter u_rr (
    .if_req     (ifReq),
    .d_req      (dReq),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign any_grant = |grant;
  assign sel_addr  = grant[GNT_D] ? dAdress : ifAdress;
  assign sel_oor   = (sel_addr >= DEPTH_LIM);
  assign busy      = (state != IDLE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_grant) next_state = sel_oor ? DONE : SETUP;
      SETUP:   next_state = STROBE;
      STROBE:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Acks, strobes and read data are all registered so they appear on
  // the cycle of the state they belong to (strobe in STROBE, ack in DONE)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_IF;
      win        <= GNT_IF;
      lat_write  <= 1'b0;
      ifAck      <= 1'b0;
      dAck       <= 1'b0;
      ifErr      <= 1'b0;
      dErr       <= 1'b0;
      ifData     <= '0;
      dRData     <= '0;
      memAdress  <= '0;
      memData    <= '0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
    end else begin
      state    <= next_state;
      ifAck    <= 1'b0;
      dAck     <= 1'b0;
      ifErr    <= 1'b0;
      dErr     <= 1'b0;
      memRead  <= 1'b0;
      memWrite <= 1'b0;
      case (state)
        IDLE: begin
          if (any_grant) begin
            win        <= grant[GNT_D] ? GNT_D : GNT_IF;
            last_grant <= grant[GNT_D] ? GNT_D : GNT_IF;
            lat_write  <= grant[GNT_D] & dWrite;
            if (sel_oor) begin
              // Rejected: acknowledge at once, memory bus untouched
              if (grant[GNT_D]) begin
                dAck <= 1'b1;
                dErr <= 1'b1;
              end else begin
                ifAck <= 1'b1;
                ifErr <= 1'b1;
              end
            end else begin
              memAdress <= sel_addr;
              if (grant[GNT_D]) memData <= dWData;
            end
          end
        end
        SETUP: begin
          memWrite <= lat_write;
          memRead  <= ~lat_write;
        end
        STROBE: begin
          if (win == GNT_D) begin
            dAck <= 1'b1;
            if (!lat_write) dRData <= memOut;
          end else begin
            ifAck  <= 1'b1;
            ifData <= memOut;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a strobe-driven memory model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifReq = 1'b0;
  logic [31:0] ifAdress = '0;
  logic        ifAck;
  logic [31:0] ifData;
  logic        dReq = 1'b0;
  logic        dWrite = 1'b0;
  logic [31:0] dAdress = '0;
  logic [31:0] dWData = '0;
  logic        dAck;
  logic [31:0] dRData;
  logic        dErr;
  logic        ifErr;
  logic [31:0] memAdress;
  logic [31:0] memData;
  logic [31:0] memOut = '0;
  logic        memRead;
  logic        memWrite;
  logic        busy;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAdress(ifAdress), .ifAck(ifAck), .ifData(ifData),
    .dReq(dReq), .dWrite(dWrite), .dAdress(dAdress), .dWData(dWData),
    .dAck(dAck), .dRData(dRData), .dErr(dErr), .ifErr(ifErr),
    .memAdress(memAdress), .memData(memData), .memOut(memOut),
    .memRead(memRead), .memWrite(memWrite), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge memWrite) mem[memAdress[7:0]] <= memData;
  always @(posedge memRead)  memOut <= mem[memAdress[7:0]];

  typedef struct {
    bit          is_d;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  bit          prev_rd = 0;
  bit          prev_wr = 0;
  bit          addr_chk = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] last_d = '0;
  logic [31:0] last_if = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input bit is_d, input bit err, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.err  = err;
    e.data = data;
    return e;
  endfunction

  // Response monitor: every ack pops the oldest expectation
  always @(negedge clk) begin
    if (!reset && (ifAck || dAck)) begin
      if (ifAck && dAck) chk("ack_exclusive", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_ack", {ifAck, dAck}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_port", dAck, e.is_d);
        if (e.is_d) begin
          chk("d_err", dErr, e.err);
          chk("d_rdata", dRData, e.data);
        end else begin
          chk("if_err", ifErr, e.err);
          chk("if_data", ifData, e.data);
        end
      end
    end
  end

  // Strobe monitor: pulse width, exclusivity and address at strobe time
  always @(negedge clk) begin
    if (memRead && memWrite) chk("strobe_exclusive", 1, 0);
    if (memRead && prev_rd) chk("read_width", 2, 1);
    if (memWrite && prev_wr) chk("write_width", 2, 1);
    if (memRead) rd_cnt++;
    if (memWrite) wr_cnt++;
    if ((memRead || memWrite) && addr_chk) chk("strobe_addr", memAdress, exp_addr);
    prev_rd = memRead;
    prev_wr = memWrite;
  end

  task automatic access(input string name, input bit is_d, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input bit err, input int lat);
    int rd0, wr0, c;
    bit got;
    logic [31:0] ed;
    rd0 = rd_cnt; wr0 = wr_cnt; c = 0; got = 0;
    if (is_d) begin
      ed = (err || wr) ? last_d : rdata;
      last_d = ed;
    end else begin
      ed = err ? last_if : rdata;
      last_if = ed;
    end
    q.push_back(mk(is_d, err, ed));
    exp_addr = addr;
    addr_chk = 1;
    @(negedge clk);
    if (is_d) begin
      dReq = 1; dWrite = wr; dAdress = addr; dWData = wdata;
    end else begin
      ifReq = 1; ifAdress = addr;
    end
    while (c < 20 && !got) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (is_d ? dAck : ifAck) got = 1;
    end
    chk({name, "_busy_at_ack"}, busy, got);
    dReq = 0; ifReq = 0;
    chk({name, "_latency"}, got ? c : -1, lat);
    chk({name, "_reads"}, rd_cnt - rd0, (!err && !wr) ? 1 : 0);
    chk({name, "_writes"}, wr_cnt - wr0, (!err && wr) ? 1 : 0);
    addr_chk = 0;
  endtask

  task automatic tie(input string name, input bit d_first,
                     input logic [31:0] d_addr, input logic [31:0] d_data,
                     input logic [31:0] i_addr, input logic [31:0] i_data);
    int c, dl, il;
    c = 0; dl = -1; il = -1;
    if (d_first) begin
      q.push_back(mk(1, 0, d_data));
      q.push_back(mk(0, 0, i_data));
    end else begin
      q.push_back(mk(0, 0, i_data));
      q.push_back(mk(1, 0, d_data));
    end
    last_d = d_data; last_if = i_data;
    @(negedge clk);
    dReq = 1; dWrite = 0; dAdress = d_addr;
    ifReq = 1; ifAdress = i_addr;
    while (c < 30 && (dl < 0 || il < 0)) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (dAck) begin dl = c; dReq = 0; end
      if (ifAck) begin il = c; ifReq = 0; end
    end
    dReq = 0; ifReq = 0;
    chk({name, "_d_latency"}, dl, d_first ? 3 : 7);
    chk({name, "_if_latency"}, il, d_first ? 7 : 3);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {memRead, memWrite, ifAck, dAck, ifErr, dErr, busy}, 0);
    chk("reset_data", {ifData, dRData}, 0);
    chk("reset_bus", {memAdress, memData}, 0);
    reset = 0;

    access("store5", 1, 1, 5, 32'hDEADBEEF, 0, 0, 3);
    access("load5", 1, 0, 5, 0, 32'hDEADBEEF, 0, 3);
    access("fetch5", 0, 0, 5, 0, 32'hDEADBEEF, 0, 3);
    access("store199", 1, 1, 199, 32'h12345678, 0, 0, 3);
    access("load199", 1, 0, 199, 0, 32'h12345678, 0, 3);
    access("load200", 1, 0, 200, 0, 0, 1, 1);
    access("storeFFFF", 1, 1, 32'hFFFFFFFF, 32'hCAFEF00D, 0, 1, 1);
    access("fetch200", 0, 0, 200, 0, 0, 1, 1);
    access("reload5", 1, 0, 5, 0, 32'hDEADBEEF, 0, 3);

    // Reset while a read strobe is on the bus
    @(negedge clk);
    ifReq = 1; ifAdress = 5;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("midreset_strobe_before", memRead, 1);
    reset = 1;
    #1;
    chk("midreset_strobe_async", memRead, 0);
    chk("midreset_busy", busy, 0);
    ifReq = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_no_ack", {ifAck, dAck}, 0);
    reset = 0;
    last_d = '0; last_if = '0;

    tie("tie1", 1, 5, 32'hDEADBEEF, 199, 32'h12345678);
    tie("tie2", 1, 199, 32'h12345678, 5, 32'hDEADBEEF);
    access("refetch5", 0, 0, 5, 0, 32'hDEADBEEF, 0, 3);
    access("load199b", 1, 0, 199, 0, 32'h12345678, 0, 3);
    tie("tie3", 0, 5, 32'hDEADBEEF, 199, 32'h12345678);

    // Request left high one cycle after ack is served again
    begin
      int c, n, first, second, rd0;
      c = 0; n = 0; first = -1; second = -1; rd0 = rd_cnt;
      q.push_back(mk(1, 0, 32'h12345678));
      q.push_back(mk(1, 0, 32'h12345678));
      @(negedge clk);
      dReq = 1; dWrite = 0; dAdress = 199;
      while (c < 20 && n < 2) begin
        @(posedge clk);
        c++;
        @(negedge clk);
        if (c == 5) dReq = 0;
        if (dAck) begin
          n++;
          if (n == 1) first = c; else second = c;
        end
      end
      dReq = 0;
      chk("held_first_ack", first, 3);
      chk("held_second_ack", second, 7);
      chk("held_reads", rd_cnt - rd0, 2);
    end

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
